// File: rtl/regfile_sb.sv
// regfile_sb: register file with a write-pending scoreboard. Two combinational
// read ports, optional same-cycle write bypass, optional hardwired-zero register 0.
module regfile_sb #(
  parameter int WIDTH    = 32,
  parameter int AWIDTH   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic [AWIDTH-1:0] Ra,
  input  logic [AWIDTH-1:0] Rb,
  output logic [WIDTH-1:0]  Qa,
  output logic [WIDTH-1:0]  Qb,
  input  logic [AWIDTH-1:0] Wr,
  input  logic [WIDTH-1:0]  D,
  input  logic              We,
  input  logic              Iss,
  input  logic [AWIDTH-1:0] Rs,
  input  logic              Flush,
  output logic              BusyA,
  output logic              BusyB,
  output logic [AWIDTH:0]   Pending
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [AWIDTH:0]  pend_q, pend_d;
  logic             ew, ei, inc, dec;

  assign ew = We  && !(ZR && (Wr == '0));
  assign ei = Iss && !(ZR && (Rs == '0));

  always_comb begin
    busy_d = busy_q;
    if (Flush) begin
      busy_d = '0;
    end else begin
      // Clear first so a same-register issue (new producer) wins.
      if (ew) busy_d[Wr] = 1'b0;
      if (ei) busy_d[Rs] = 1'b1;
    end
  end

  always_comb begin
    inc    = ei && !busy_q[Rs];
    dec    = ew && busy_q[Wr] && !(ei && (Rs == Wr));
    pend_d = '0;
    if (!Flush)
      pend_d = pend_q + {{AWIDTH{1'b0}}, inc} - {{AWIDTH{1'b0}}, dec};
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (ew) begin
      regs_q[Wr] <= D;
    end
  end

  always_comb begin
    Qa = regs_q[Ra];
    if (ZR && (Ra == '0))           Qa = '0;
    else if (BP && We && (Wr == Ra)) Qa = D;
    Qb = regs_q[Rb];
    if (ZR && (Rb == '0))           Qb = '0;
    else if (BP && We && (Wr == Rb)) Qb = D;
  end

  always_comb begin
    BusyA = busy_q[Ra] && !(BP && ew && (Wr == Ra)) && !(ZR && (Ra == '0));
    BusyB = busy_q[Rb] && !(BP && ew && (Wr == Rb)) && !(ZR && (Rb == '0));
  end

  assign Pending = pend_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: two instances (bypass+zero-reg, and neither)
// share stimulus; expected outputs are queued and checked by a separate monitor.
module tb_regfile_sb;

  logic        Clk = 1'b0;
  logic        Clrn;
  logic [4:0]  Ra, Rb, Wr, Rs;
  logic [31:0] D;
  logic        We, Iss, Flush;
  logic [31:0] Qa1, Qb1, Qa0, Qb0;
  logic        BusyA1, BusyB1, BusyA0, BusyB0;
  logic [5:0]  Pend1, Pend0;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  regfile_sb #(.WIDTH(32), .AWIDTH(5), .ZERO_REG(1), .BYPASS(1)) u1 (
    .Clk(Clk), .Clrn(Clrn), .Ra(Ra), .Rb(Rb), .Qa(Qa1), .Qb(Qb1),
    .Wr(Wr), .D(D), .We(We), .Iss(Iss), .Rs(Rs), .Flush(Flush),
    .BusyA(BusyA1), .BusyB(BusyB1), .Pending(Pend1));

  regfile_sb #(.WIDTH(32), .AWIDTH(5), .ZERO_REG(0), .BYPASS(0)) u0 (
    .Clk(Clk), .Clrn(Clrn), .Ra(Ra), .Rb(Rb), .Qa(Qa0), .Qb(Qb0),
    .Wr(Wr), .D(D), .We(We), .Iss(Iss), .Rs(Rs), .Flush(Flush),
    .BusyA(BusyA0), .BusyB(BusyB0), .Pending(Pend0));

  typedef struct {
    logic [31:0] qa [2];
    logic [31:0] qb [2];
    logic        ba [2];
    logic        bb [2];
    logic [5:0]  pend [2];
  } exp_t;

  exp_t exp_q [$];

  // Reference model: index 1 = ZERO_REG/BYPASS on, index 0 = both off.
  logic [31:0] mregs [2][32];
  logic        mbusy [2][32];

  function automatic bit zr(int k); return k == 1; endfunction
  function automatic bit bp(int k); return k == 1; endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++) begin
        mregs[k][r] = '0;
        mbusy[k][r] = 1'b0;
      end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit ew, ei;
      ew = We  && !(zr(k) && Wr == 0);
      ei = Iss && !(zr(k) && Rs == 0);
      if (ew) mregs[k][Wr] = D;
      if (Flush) begin
        for (int r = 0; r < 32; r++) mbusy[k][r] = 1'b0;
      end else begin
        if (ew) mbusy[k][Wr] = 1'b0;
        if (ei) mbusy[k][Rs] = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] mread(int k, logic [4:0] a);
    if (zr(k) && a == 0) return '0;
    if (bp(k) && We && Wr == a) return D;
    return mregs[k][a];
  endfunction

  function automatic logic mbusy_out(int k, logic [4:0] a);
    bit ew;
    ew = We && !(zr(k) && Wr == 0);
    if (zr(k) && a == 0) return 1'b0;
    return mbusy[k][a] && !(bp(k) && ew && Wr == a);
  endfunction

  task automatic push_expected();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      int cnt;
      cnt = 0;
      for (int r = 0; r < 32; r++) cnt += int'(mbusy[k][r]);
      e.qa[k]   = mread(k, Ra);
      e.qb[k]   = mread(k, Rb);
      e.ba[k]   = mbusy_out(k, Ra);
      e.bb[k]   = mbusy_out(k, Rb);
      e.pend[k] = 6'(cnt);
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s t=%0t actual=0x%0h expected=0x%0h", name, $time, act, expv);
    end
  endtask

  // Monitor: outputs are combinational/registered, so every cycle presents a sample.
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("Qa_b1",   Qa1,            e.qa[1]);
      chk("Qb_b1",   Qb1,            e.qb[1]);
      chk("BusyA_b1", 32'(BusyA1),   32'(e.ba[1]));
      chk("BusyB_b1", 32'(BusyB1),   32'(e.bb[1]));
      chk("Pend_b1", 32'(Pend1),     32'(e.pend[1]));
      chk("Qa_b0",   Qa0,            e.qa[0]);
      chk("Qb_b0",   Qb0,            e.qb[0]);
      chk("BusyA_b0", 32'(BusyA0),   32'(e.ba[0]));
      chk("BusyB_b0", 32'(BusyB0),   32'(e.bb[0]));
      chk("Pend_b0", 32'(Pend0),     32'(e.pend[0]));
    end
  end

  // One clock cycle: commit the previous cycle's inputs into the model at the
  // edge, then drive new inputs and queue the expected response.
  task automatic cyc(input logic we_v, input logic [4:0] wr_v, input logic [31:0] d_v,
                     input logic iss_v, input logic [4:0] rs_v, input logic fl_v,
                     input logic [4:0] ra_v, input logic [4:0] rb_v);
    @(posedge Clk);
    model_edge();
    #1;
    We = we_v; Wr = wr_v; D = d_v; Iss = iss_v; Rs = rs_v; Flush = fl_v;
    Ra = ra_v; Rb = rb_v;
    #1;
    push_expected();
  endtask

  // Asynchronous reset pulse in the middle of a cycle, released before the next edge.
  task automatic reset_pulse(input logic [4:0] ra_v);
    @(posedge Clk);
    model_edge();
    #1;
    We = 0; Iss = 0; Flush = 0; Ra = ra_v; Rb = ra_v;
    #1;
    Clrn = 1'b0;
    model_reset();
    #1;
    push_expected();
    @(negedge Clk);
    #1;
    Clrn = 1'b1;
  endtask

  initial begin
    Clrn = 1'b0; We = 0; Iss = 0; Flush = 0;
    Ra = 0; Rb = 0; Wr = 0; Rs = 0; D = '0;
    model_reset();
    #1;
    push_expected();
    @(negedge Clk);
    #2 Clrn = 1'b1;

    // Reset mid-operation clears stored data and pending state.
    cyc(1, 5, 32'hDEADBEEF, 1, 5, 0, 5, 5);
    cyc(0, 0, 0, 1, 8, 0, 5, 8);
    reset_pulse(5);
    cyc(0, 0, 0, 0, 0, 0, 5, 8);

    // Register 0: writes and issues dropped only on the zero-reg instance.
    cyc(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Bypass: same-cycle forward vs. one-cycle-later visibility.
    cyc(1, 7, 32'h1234, 0, 0, 0, 7, 7);
    cyc(0, 0, 0, 0, 0, 0, 7, 7);

    // Scoreboard counting: re-issue, writeback, set-wins-over-clear.
    cyc(1, 4, 32'h0, 1, 3, 0, 3, 4);
    cyc(0, 0, 0, 1, 4, 0, 3, 4);
    cyc(0, 0, 0, 1, 3, 0, 3, 4);
    cyc(1, 4, 32'h44, 0, 0, 0, 3, 4);
    cyc(1, 3, 32'h33, 1, 3, 0, 3, 4);
    cyc(0, 0, 0, 0, 0, 0, 3, 4);

    // Simultaneous issue and writeback on different registers.
    cyc(0, 0, 0, 1, 2, 0, 2, 9);
    cyc(1, 2, 32'h22, 1, 9, 0, 2, 9);
    cyc(0, 0, 0, 0, 0, 0, 2, 9);

    // Flush with concurrent issue and write.
    cyc(0, 0, 0, 1, 10, 0, 6, 1);
    cyc(0, 0, 0, 1, 11, 0, 6, 1);
    cyc(1, 1, 32'hAA, 1, 6, 1, 6, 1);
    cyc(0, 0, 0, 0, 0, 0, 6, 1);

    // Fill every register busy to reach the top of the Pending range.
    for (int r = 0; r < 32; r++) cyc(0, 0, 0, 1, 5'(r), 0, 5'(r), 0);
    cyc(0, 0, 0, 0, 0, 0, 31, 1);
    for (int r = 0; r < 32; r++) cyc(1, 5'(r), $urandom, 0, 0, 0, 5'(r), 5'(r ^ 1));

    // Randomized traffic, biased toward a small address range for more hazards.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] wr_v, rs_v, ra_v, rb_v;
      wr_v = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rs_v = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      ra_v = ($urandom_range(0, 1) == 0) ? wr_v : 5'($urandom_range(0, 7));
      rb_v = ($urandom_range(0, 1) == 0) ? rs_v : 5'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0)
        reset_pulse(ra_v);
      else
        cyc(1'($urandom), wr_v, $urandom, 1'($urandom), rs_v,
            ($urandom_range(0, 39) == 0), ra_v, rb_v);
    end

    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge Clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0 (unchecked samples)", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
